mem_access_unit: RTL
====================

# mem_access_unit

Load/store front-end for the multi-cycle CPU, sitting directly upstream of the combined instruction/data memory (word-addressed, combinational read gated by `MemRead`, word write on `posedge clk` when `MemWrite`). Accepts byte/half/word load and store requests from the datapath and turns them into word-aligned memory cycles. Sub-word stores become a read-modify-write pair, and sub-word loads are lane-extracted and sign- or zero-extended.

## Interface
Parameters:
- `ADDR_W`, 32, width of byte address and memory `Address`.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  access request; sampled only while `busy`=0.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- `sign_ext`  in  1  loads only: 1 sign-extend, 0 zero-extend.
- `addr`  in  ADDR_W  byte address.
- `wdata`  in  32  store data, right-justified.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle completion pulse.
- `misalign`  out  1  valid with `done`; access was suppressed.
- `rdata`  out  32  registered load result, held until the next load completes.
- `Address`  out  ADDR_W  `{addr_q[ADDR_W-1:2],2'b00}`.
- `Write_data`  out  32  memory write word.
- `MemRead`  out  1  memory read enable.
- `MemWrite`  out  1  memory write enable.
- `Mem_data`  in  32  memory read word.

## Operation
- On an accepted request, `addr`, `wdata`, `size`, `we` and `sign_ext` are latched. Later input changes have no effect.
- Lanes are little-endian.
  - Byte k = `addr_q[1:0]`, bits [8k+7:8k].
  - Half h = `addr_q[1]`, bits [16h+15:16h].
- FSM states: IDLE, ACCESS, RMW_RD, RMW_WR, FIN.
- IDLE:
  - `req`=1 and misaligned → FIN, with `misalign` set.
  - Otherwise, a load or word store → ACCESS.
  - Otherwise, a byte/half store → RMW_RD.
- ACCESS:
  - Load: `MemRead`=1. The extracted and extended lane is registered into `rdata`.
  - Word store: `MemWrite`=1, `Write_data`=`wdata_q`.
  - Next state is FIN.
- RMW_RD: `MemRead`=1. `Mem_data` is registered into `merge_q`. Next state is RMW_WR.
- RMW_WR: `MemWrite`=1. `Write_data`=`merge_q` with the target lane replaced by the low byte/half of `wdata_q`. Next state is FIN.
- FIN: `done`=1, `misalign` valid. Next state is IDLE. `req` is ignored here and can be accepted again on the following IDLE cycle.
- `MemRead` and `MemWrite` are decoded from registered state only. They are 0 in IDLE and FIN and are never both high.
- Misaligned means a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0. Byte accesses are never misaligned.

## Timing
- Reset values:
  - state IDLE; `busy` 0, `done` 0, `misalign` 0, `rdata` 0.
  - `MemRead` 0, `MemWrite` 0; `Address` 0, `Write_data` 0.
- Latency, counted from the accepting edge:
  - Load or word store: `done` in the 2nd cycle after acceptance.
  - Sub-word store: `done` in the 3rd cycle.
  - Misaligned access: `done` in the 1st cycle.
- Store data is committed to memory on the edge ending ACCESS or RMW_WR.
- `rdata` updates on the edge ending ACCESS and is valid during FIN.
- Reset asserted mid-operation: state returns to IDLE immediately and `MemWrite` drops asynchronously. No partial write may land. A request in flight is lost, with no `done` pulse.
- `req` held high across FIN: a new access is accepted on the first IDLE edge. Throughput is one access per 3 cycles (word) or 4 cycles (sub-word).

## Configuration
- `MEM_ACCESS_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses go IDLE→FIN with `misalign`=1.
  - No memory enable is asserted, and `rdata` is unchanged.
- Not defined:
  - Low address bits are ignored for alignment: half uses `addr[1]`, word uses the aligned word.
  - Every access proceeds normally, and `misalign` is tied to 0.

## Test plan
- Word store 0xDEADBEEF @0x100, then word load @0x100 → memory word 64 = 0xDEADBEEF. `rdata`=0xDEADBEEF, with `done` 2 cycles after each accept.
- Word store 0x11223344 @0x100, then byte store 0x000000A5 @0x103 → `MemRead` one cycle, then `MemWrite` one cycle. Word = 0xA5223344, `done` 3 cycles after accept.
- Byte load @0x103 with `sign_ext`=1 → 0xFFFFFFA5. With `sign_ext`=0 → 0x000000A5. Byte load @0x101, `sign_ext`=1 → 0x00000033.
- Half store 0x00007777 @0x102 → word 0x77773344. Half load @0x102 → 0x00007777. Half load @0x100, `sign_ext`=1 → 0x00003344.
- Word load @0x101:
  - Macro defined: `done`=`misalign`=1 one cycle after accept, `MemRead`/`MemWrite` never high, `rdata` unchanged.
  - Macro undefined: `rdata`=contents of 0x100.
- `reset` pulsed during RMW_RD of a byte store @0x100 → `busy` 0 immediately, no `MemWrite` pulse, no `done`. The next request is accepted normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request and memory bus bundle for mem_access_unit
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    // datapath request side
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              misalign;
    logic [31:0]       rdata;
    // word-addressed memory side
    logic [ADDR_W-1:0] Address;
    logic [31:0]       Write_data;
    logic              MemRead;
    logic              MemWrite;
    logic [31:0]       Mem_data;

    // the access unit itself
    modport slave (
        input  req, we, size, sign_ext, addr, wdata, Mem_data,
        output busy, done, misalign, rdata, Address, Write_data, MemRead, MemWrite
    );

    // the datapath plus memory environment around the unit
    modport master (
        output req, we, size, sign_ext, addr, wdata, Mem_data,
        input  busy, done, misalign, rdata, Address, Write_data, MemRead, MemWrite
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store front-end; MEM_ACCESS_MISALIGN_TRAP_EN enables misalign trapping
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, FIN} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              sign_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;
    logic              req_mis;
    logic [31:0]       load_val;
    logic [31:0]       merged;
    logic [31:0]       lane_shift;
    logic [15:0]       half_lane;
    logic              busy_c, done_c, rd_c, wr_c;
    logic [31:0]       wd_c;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic              mis_q;

    assign req_mis = ((bus.size == 2'b01) && bus.addr[0]) ||
                     (bus.size[1] && (bus.addr[1:0] != 2'b00));
    assign bus.misalign = (state == FIN) && mis_q;
`else
    // without trapping the low address bits simply select lanes / words
    assign req_mis = 1'b0;
    assign bus.misalign = 1'b0;
`endif

    // state register; reset aborts any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // next state and memory strobes, decoded from registered state only
    always_comb begin
        next_state = state;
        busy_c     = 1'b1;
        done_c     = 1'b0;
        rd_c       = 1'b0;
        wr_c       = 1'b0;
        wd_c       = 32'h0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.req) begin
                    if (req_mis)                     next_state = FIN;
                    else if (!bus.we || bus.size[1]) next_state = ACCESS;
                    else                             next_state = RMW_RD;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    wr_c = 1'b1;
                    wd_c = wdata_q;
                end else begin
                    rd_c = 1'b1;
                end
                next_state = FIN;
            end
            RMW_RD: begin
                rd_c       = 1'b1;
                next_state = RMW_WR;
            end
            RMW_WR: begin
                wr_c       = 1'b1;
                wd_c       = merged;
                next_state = FIN;
            end
            FIN: begin
                done_c     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // lane extraction for loads and lane insertion for sub-word stores
    always_comb begin
        lane_shift = bus.Mem_data >> {addr_q[1:0], 3'b000};
        half_lane  = addr_q[1] ? bus.Mem_data[31:16] : bus.Mem_data[15:0];
        case (size_q)
            2'b00:   load_val = {{24{sign_q & lane_shift[7]}}, lane_shift[7:0]};
            2'b01:   load_val = {{16{sign_q & half_lane[15]}}, half_lane};
            default: load_val = bus.Mem_data;
        endcase
        merged = merge_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // request capture, read-modify-write buffer and load result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            if (state == IDLE && bus.req) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                size_q  <= bus.size;
                we_q    <= bus.we;
                sign_q  <= bus.sign_ext;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                mis_q   <= req_mis;
`endif
            end
            if (state == ACCESS && !we_q) rdata_q <= load_val;
            if (state == RMW_RD)          merge_q <= bus.Mem_data;
        end
    end

    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.MemRead    = rd_c;
    assign bus.MemWrite   = wr_c;
    assign bus.Write_data = wd_c;
    assign bus.rdata      = rdata_q;
    assign bus.Address    = {addr_q[ADDR_W-1:2], 2'b00};
endmodule
